// File: rtl/noc_alloc_pkg.sv
// Shared types and sizing helpers for the NoC switch allocator.
package noc_alloc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } out_state_e;

  // Width needed to hold a credit count in the range 0..credits
  function automatic int unsigned credit_w(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

  // Width of an input index, at least one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_hold.sv
// Per-output round-robin arbiter that holds the output for a wormhole packet.
module rr_arbiter_hold
  import noc_alloc_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [0:N-1] req,
  input  logic [0:N-1] tail,
  output logic [0:N-1] grant,
  output logic         locked
);

  localparam int unsigned IW = idx_w(N);

  out_state_e    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic          found;
  logic          fire;

  // Pick a winner: round-robin search from ptr when idle, owner only when locked
  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
    if (state == IDLE) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!found && req[IW'((32'(ptr) + k) % N)]) begin
          found = 1'b1;
          sel   = IW'((32'(ptr) + k) % N);
        end
      end
    end else if (req[owner]) begin
      found = 1'b1;
      sel   = owner;
    end
    if (en && found) begin
      grant[sel] = 1'b1;
    end
  end

  assign fire   = en && found;
  assign locked = (state == LOCKED);

  // Advance pointer and lock/unlock the output on each granted flit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
    end else if (fire) begin
      if (state == IDLE) begin
        ptr <= IW'((32'(sel) + 1) % N);
        if (!tail[sel]) begin
          state <= LOCKED;
          owner <= sel;
        end
      end else if (tail[owner]) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: rtl/wormhole_switch_alloc.sv
// Wormhole switch allocator: per-output packet-holding arbitration with credit flow control.
`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif

module wormhole_switch_alloc
  import noc_alloc_pkg::*;
#(
  parameter  int unsigned N       = `N,
  parameter  int unsigned M       = `M,
  parameter  int unsigned CREDITS = 4,
  localparam int unsigned CW      = credit_w(CREDITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [0:N-1][0:M-1]   i_output_req,
  input  logic [0:N-1]          i_tail,
  input  logic [0:M-1]          i_credit_ret,
  output logic [0:M-1][0:N-1]   o_output_grant,
  output logic [0:N-1]          o_input_grant,
  output logic [0:M-1]          o_locked,
  output logic [0:M-1][CW-1:0]  o_credits
);

  localparam int unsigned SW = CW + 1;

  logic [0:N-1][0:M-1] req_clean;
  logic [0:N-1]        gnt [M];
  logic [0:M-1]        lk;
  logic [CW-1:0]       credits_q [M];

  // Reduce each input's request to its lowest-index output
  always_comb begin
    logic hit;
    req_clean = '0;
    for (int unsigned j = 0; j < N; j++) begin
      hit = 1'b0;
      for (int unsigned i = 0; i < M; i++) begin
        if (!hit && i_output_req[j][i]) begin
          req_clean[j][i] = 1'b1;
          hit             = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_out
    logic [0:N-1]  col;
    logic          en;
    logic          g_any;
    logic [SW-1:0] sum;
    logic [CW-1:0] nxt;

    // Gather the requests aimed at this output
    always_comb begin
      col = '0;
      for (int unsigned j = 0; j < N; j++) begin
        col[j] = req_clean[j][i];
      end
    end

    assign en    = ce && !reset && (credits_q[i] != '0);
    assign g_any = |gnt[i];

    rr_arbiter_hold #(.N(N)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .req    (col),
      .tail   (i_tail),
      .grant  (gnt[i]),
      .locked (lk[i])
    );

    // Credit next value: consume on grant, add on return, saturate at CREDITS
    always_comb begin
      sum = SW'(credits_q[i]) - SW'(g_any) + SW'(i_credit_ret[i]);
      if (sum > SW'(CREDITS)) begin
        nxt = CW'(CREDITS);
      end else begin
        nxt = CW'(sum);
      end
    end

    // Credit counter runs regardless of ce so returns are never lost
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        credits_q[i] <= CW'(CREDITS);
      end else begin
        credits_q[i] <= nxt;
      end
    end
  end

  // Drive the output-side buses and the per-input FIFO read enables
  always_comb begin
    o_input_grant = '0;
    for (int unsigned i = 0; i < M; i++) begin
      o_output_grant[i] = gnt[i];
      o_locked[i]       = lk[i];
      o_credits[i]      = credits_q[i];
      o_input_grant     = o_input_grant | gnt[i];
    end
  end

endmodule

// File: tb/tb_wormhole_switch_alloc.sv
// Directed self-checking bench for wormhole_switch_alloc (N=5, M=5, CREDITS=4).
module tb_wormhole_switch_alloc;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ce = 1'b0;
  logic [0:4][0:4]  req;
  logic [0:4]       tail;
  logic [0:4]       cret;
  logic [0:4][0:4]  og;
  logic [0:4]       ig;
  logic [0:4]       locked;
  logic [0:4][2:0]  credits;

  int n_checks = 0;
  int n_fail   = 0;

  wormhole_switch_alloc #(.N(5), .M(5), .CREDITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ce             (ce),
    .i_output_req   (req),
    .i_tail         (tail),
    .i_credit_ret   (cret),
    .o_output_grant (og),
    .o_input_grant  (ig),
    .o_locked       (locked),
    .o_credits      (credits)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req  = '0;
    tail = '0;
    cret = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    ce = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [0:4][2:0] full;
    full = {5{3'd4}};
    reset = 1'b1;
    ce = 1'b1;
    clear_inputs();
    for (int j = 0; j < 5; j++) req[j][0] = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (og !== '0) begin n_fail++; $display("FAIL reset_grant: got %h expected 0", og); end
    n_checks++; if (ig !== '0) begin n_fail++; $display("FAIL reset_in_grant: got %h expected 0", ig); end
    n_checks++; if (locked !== '0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_checks++; if (credits !== full) begin n_fail++; $display("FAIL reset_credits: got %h expected %h", credits, full); end
    step();
    n_checks++; if (og !== '0) begin n_fail++; $display("FAIL reset_grant_held: got %h expected 0", og); end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_wormhole();
    int r1 [7]   = '{1, 1, 1, 0, 0, 0, 0};
    int r3 [7]   = '{1, 1, 1, 1, 1, 1, 0};
    int t1 [7]   = '{0, 0, 1, 0, 0, 0, 0};
    int t3 [7]   = '{0, 0, 0, 0, 0, 1, 0};
    int rt [7]   = '{0, 1, 0, 1, 0, 1, 0};
    int eg [7]   = '{1, 1, 1, 3, 3, 3, -1};
    int el [7]   = '{0, 1, 1, 0, 1, 1, 0};
    int ec [7]   = '{4, 3, 3, 2, 2, 1, 1};
    logic [0:4] ev;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      req[1][2] = r1[c][0];
      req[3][2] = r3[c][0];
      tail[1]   = t1[c][0];
      tail[3]   = t3[c][0];
      cret[2]   = rt[c][0];
      ev = '0;
      if (eg[c] >= 0) ev[eg[c]] = 1'b1;
      #1;
      n_checks++; if (og[2] !== ev) begin n_fail++; $display("FAIL worm_grant c%0d: got %b expected %b", c, og[2], ev); end
      n_checks++; if (ig !== ev) begin n_fail++; $display("FAIL worm_in_grant c%0d: got %b expected %b", c, ig, ev); end
      n_checks++; if (locked[2] !== el[c][0]) begin n_fail++; $display("FAIL worm_locked c%0d: got %b expected %0d", c, locked[2], el[c]); end
      n_checks++; if (credits[2] !== 3'(ec[c])) begin n_fail++; $display("FAIL worm_credits c%0d: got %0d expected %0d", c, credits[2], ec[c]); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [0:4] ev;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      clear_inputs();
      for (int j = 0; j < 5; j++) req[j][0] = 1'b1;
      tail = 5'b11111;
      cret[0] = (c > 0);
      ev = '0;
      ev[c % 5] = 1'b1;
      #1;
      n_checks++; if (og[0] !== ev) begin n_fail++; $display("FAIL rr_grant c%0d: got %b expected %b", c, og[0], ev); end
      n_checks++; if (locked[0] !== 1'b0) begin n_fail++; $display("FAIL rr_locked c%0d: got %b expected 0", c, locked[0]); end
      n_checks++; if (credits[0] !== ((c == 0) ? 3'd4 : 3'd3)) begin n_fail++; $display("FAIL rr_credits c%0d: got %0d", c, credits[0]); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_credits();
    int rt [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int eg [8] = '{1, 1, 1, 1, 0, 0, 1, 0};
    int ec [8] = '{4, 3, 2, 1, 0, 0, 1, 0};
    logic [0:4] ev;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      req[0][1] = 1'b1;
      tail[0]   = 1'b1;
      cret[1]   = rt[c][0];
      ev = '0;
      ev[0] = eg[c][0];
      #1;
      n_checks++; if (og[1] !== ev) begin n_fail++; $display("FAIL cred_grant c%0d: got %b expected %b", c, og[1], ev); end
      n_checks++; if (credits[1] !== 3'(ec[c])) begin n_fail++; $display("FAIL cred_count c%0d: got %0d expected %0d", c, credits[1], ec[c]); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_credit_same_cycle();
    int rq [7] = '{1, 1, 1, 0, 0, 0, 0};
    int rt [7] = '{0, 0, 1, 1, 1, 1, 0};
    int ec [7] = '{4, 3, 2, 2, 3, 4, 4};
    logic [0:4] ev;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      req[4][1] = rq[c][0];
      tail[4]   = 1'b1;
      cret[1]   = rt[c][0];
      ev = '0;
      ev[4] = rq[c][0];
      #1;
      n_checks++; if (og[1] !== ev) begin n_fail++; $display("FAIL same_grant c%0d: got %b expected %b", c, og[1], ev); end
      n_checks++; if (credits[1] !== 3'(ec[c])) begin n_fail++; $display("FAIL same_credits c%0d: got %0d expected %0d", c, credits[1], ec[c]); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_lowest_bit();
    do_reset();
    req[0][1] = 1'b1;
    req[0][3] = 1'b1;
    tail[0]   = 1'b1;
    #1;
    n_checks++; if (og[1] !== 5'b10000) begin n_fail++; $display("FAIL low_grant1: got %b expected 10000", og[1]); end
    n_checks++; if (og[3] !== 5'b00000) begin n_fail++; $display("FAIL low_grant3: got %b expected 00000", og[3]); end
    step();
    clear_inputs();
    #1;
    n_checks++; if (credits[1] !== 3'd3) begin n_fail++; $display("FAIL low_cred1: got %0d expected 3", credits[1]); end
    n_checks++; if (credits[3] !== 3'd4) begin n_fail++; $display("FAIL low_cred3: got %0d expected 4", credits[3]); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req[2][4] = 1'b1;
    #1;
    n_checks++; if (og[4] !== 5'b00100) begin n_fail++; $display("FAIL mid_first: got %b expected 00100", og[4]); end
    step();
    #1;
    n_checks++; if (locked[4] !== 1'b1) begin n_fail++; $display("FAIL mid_locked: got %b expected 1", locked[4]); end
    reset = 1'b1;
    #1;
    n_checks++; if (og !== '0) begin n_fail++; $display("FAIL mid_rst_grant: got %h expected 0", og); end
    n_checks++; if (locked[4] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_locked: got %b expected 0", locked[4]); end
    n_checks++; if (credits[4] !== 3'd4) begin n_fail++; $display("FAIL mid_rst_credits: got %0d expected 4", credits[4]); end
    step();
    reset = 1'b0;
    clear_inputs();
    req[0][4] = 1'b1;
    req[2][4] = 1'b1;
    tail[0]   = 1'b1;
    tail[2]   = 1'b1;
    #1;
    n_checks++; if (og[4] !== 5'b10000) begin n_fail++; $display("FAIL mid_after: got %b expected 10000", og[4]); end
    step();
    clear_inputs();
  endtask

  task automatic test_ce_hold();
    do_reset();
    req[1][3] = 1'b1;
    #1;
    n_checks++; if (og[3] !== 5'b01000) begin n_fail++; $display("FAIL ce_first: got %b expected 01000", og[3]); end
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      ce = 1'b0;
      clear_inputs();
      req[1][3] = 1'b1;
      req[0][3] = 1'b1;
      cret[3]   = (c < 2);
      #1;
      n_checks++; if (og !== '0) begin n_fail++; $display("FAIL ce_grant c%0d: got %h expected 0", c, og); end
      n_checks++; if (ig !== '0) begin n_fail++; $display("FAIL ce_in_grant c%0d: got %b expected 0", c, ig); end
      n_checks++; if (locked[3] !== 1'b1) begin n_fail++; $display("FAIL ce_locked c%0d: got %b expected 1", c, locked[3]); end
      if (c == 0) begin
        n_checks++; if (credits[3] !== 3'd2) begin n_fail++; $display("FAIL ce_cred_start: got %0d expected 2", credits[3]); end
      end
      step();
    end
    ce = 1'b1;
    cret = '0;
    #1;
    n_checks++; if (credits[3] !== 3'd4) begin n_fail++; $display("FAIL ce_cred_end: got %0d expected 4", credits[3]); end
    n_checks++; if (locked[3] !== 1'b1) begin n_fail++; $display("FAIL ce_locked_end: got %b expected 1", locked[3]); end
    n_checks++; if (og[3] !== 5'b01000) begin n_fail++; $display("FAIL ce_owner: got %b expected 01000", og[3]); end
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_wormhole();
    test_round_robin();
    test_credits();
    test_credit_same_cycle();
    test_lowest_bit();
    test_reset_mid_packet();
    test_ce_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/wormhole_switch_alloc.md
WORMHOLE_SWITCH_ALLOC -- requirements
Module: wormhole_switch_alloc

Interface
REQ-001 SHALL have parameter N, default `N (config.sv), number of input ports.
REQ-002 SHALL have parameter M, default `M (config.sv), number of output ports.
REQ-003 SHALL have parameter CREDITS, default 4, downstream buffer depth per output; CREDIT_W = $clog2(CREDITS+1).
REQ-004 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ce, input, 1, clock enable.
REQ-007 SHALL have port i_output_req, input, [0:N-1][0:M-1], per-input requested output (one-hot or zero).
REQ-008 SHALL have port i_tail, input, [0:N-1], head flit of input j is a tail flit.
REQ-009 SHALL have port i_credit_ret, input, [0:M-1], one-cycle credit return pulse from downstream.
REQ-010 SHALL have port o_output_grant, output, [0:M-1][0:N-1], per-output one-hot granted input.
REQ-011 SHALL have port o_input_grant, output, [0:N-1], OR of all o_output_grant words (FIFO read enable).
REQ-012 SHALL have port o_locked, output, [0:M-1], output currently held by a packet.
REQ-013 SHALL have port o_credits, output, [0:M-1][CW-1:0], current credit count per output.

Function
REQ-014 SHALL keep per output: state {IDLE, LOCKED}, owner index, round-robin pointer, credit counter.
REQ-015 SHALL compute grants combinationally (zero latency); state updates at clk edge only when ce=1.
REQ-016 SHALL force all grants to 0 while ce=0 or reset=1.
REQ-017 SHALL use only the lowest-index set bit of a non-one-hot i_output_req[j].
REQ-018 SHALL grant output i only when credits[i] > 0.
REQ-019 IDLE: SHALL grant the first requesting input at or after pointer (wrapping N-1 -> 0); pointer <- granted+1 mod N.
REQ-020 IDLE grant with i_tail[j]=0: SHALL go LOCKED, owner <- j; with i_tail[j]=1 (single-flit packet): SHALL stay IDLE.
REQ-021 LOCKED: SHALL grant only the owner, only if it requests i; other requesters get no grant; pointer frozen.
REQ-022 LOCKED grant with i_tail[owner]=1: SHALL return to IDLE next cycle.
REQ-023 LOCKED, owner not requesting: SHALL remain LOCKED with no grant (bubble).
REQ-024 SHALL update credits as credits - grant_any + credit_ret; simultaneous grant and return leaves the value unchanged.
REQ-025 SHALL ignore a credit return arriving when credits==CREDITS (saturate, no wrap).
REQ-026 SHALL accumulate i_credit_ret even when ce=0; all other state holds while ce=0.
REQ-027 o_locked[i] SHALL be 1 exactly when the state is LOCKED.

Reset
REQ-028 On reset assertion, asynchronously: all states IDLE, owners 0, pointers 0, credits CREDITS, o_locked 0, grants 0; an in-flight packet is abandoned.
REQ-029 The first grant after reset deassertion SHALL go to the lowest-index requester.

Structure
REQ-030 SHALL define typedef out_state_e and the CREDIT_W function in shared package noc_alloc_pkg.
REQ-031 SHALL instantiate M copies of sub-module rr_arbiter_hold (pointer, lock, owner per output); credit counters live in the top.

Verification (N=5, M=5, CREDITS=4)
REQ-032 Inputs 1 and 3 request output 2, head flits, 3-flit packets -> input 1 granted 3 consecutive cycles, then input 3 for 3 cycles; o_locked[2]=1 throughout each packet.
REQ-033 Inputs 0..4 request output 0 with single-flit packets for 10 cycles, ample credits -> grant order 0,1,2,3,4,0,1,... ; o_locked[0] stays 0.
REQ-034 5 single-flit grants to output 1 with no credit return -> 4 grants, then credits=0 and no grant; one i_credit_ret pulse -> exactly one further grant.
REQ-035 Grant and i_credit_ret[1] in same cycle at credits=2 -> credits stays 2; return at credits=4 -> stays 4.
REQ-036 Reset asserted mid-packet while output 4 LOCKED to input 2 -> grants 0 immediately, o_locked[4]=0, credits=4; after release input 0 request wins over input 2.
REQ-037 ce=0 for 3 cycles with pending requests and 2 credit returns -> no grants, state held, credits +2.
